inst_fetch_bridge: RTL and testbench

Sits between the core's instruction fetch port (pc/fetch side, upstream of if_id) and the external instruction SRAM, which uses a req/addr_ok/data_ok split-transaction interface. It issues in-order fetch requests and tracks up to OUTSTANDING in-flight requests. Returned words are buffered with their PC in an output FIFO for the decode side. Flush support drops wrong-path responses after a branch or exception redirect.

---
 rtl/inst_fetch_bridge_pkg.sv | 13 +
 rtl/inst_fetch_bridge_if.sv | 37 +++
 rtl/inst_fetch_bridge_sync_fifo.sv | 74 +++++++
 rtl/inst_fetch_bridge.sv | 85 ++++++++
 tb/tb_inst_fetch_bridge.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared widths and helpers for the instruction fetch bridge and its FIFOs.
package inst_fetch_bridge_pkg;

  localparam int InstAddrWidth = 32;
  localparam int InstWidth     = 32;
  localparam int SramHsW       = 1;

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// Fetch, decode-side and SRAM handshake signals of the fetch bridge.
interface inst_fetch_bridge_if
  import inst_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W = InstAddrWidth,
  parameter int INST_W = InstWidth
) ();

  logic               fetch_req_i;
  logic [ADDR_W-1:0]  fetch_pc_i;
  logic               fetch_ready_o;
  logic               flush_i;
  logic               inst_valid_o;
  logic [INST_W-1:0]  inst_o;
  logic [ADDR_W-1:0]  inst_pc_o;
  logic               inst_ready_i;
  logic [SramHsW-1:0] sram_req_o;
  logic [ADDR_W-1:0]  sram_addr_o;
  logic [SramHsW-1:0] sram_addr_ok_i;
  logic [SramHsW-1:0] sram_data_ok_i;
  logic [INST_W-1:0]  sram_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_pc_i, flush_i, inst_ready_i,
    input  sram_addr_ok_i, sram_data_ok_i, sram_rdata_i,
    output fetch_ready_o, inst_valid_o, inst_o, inst_pc_o,
    output sram_req_o, sram_addr_o
  );

  modport master (
    output fetch_req_i, fetch_pc_i, flush_i, inst_ready_i,
    output sram_addr_ok_i, sram_data_ok_i, sram_rdata_i,
    input  fetch_ready_o, inst_valid_o, inst_o, inst_pc_o,
    input  sram_req_o, sram_addr_o
  );

endinterface

// File: rtl/inst_fetch_bridge_sync_fifo.sv
// Synchronous FIFO with clear; head registered, reads 0 when empty.
// Latency: push visible at head next cycle; backpressure: push dropped when full, pop ignored when empty.
module inst_fetch_bridge_sync_fifo
  import inst_fetch_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  input  logic                       clr,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             empty, full, do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push_vld && !full && !clr;
  assign do_pop  = pop_rdy && !empty && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = nxt(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = nxt(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/inst_fetch_bridge.sv
// In-order fetch bridge to split-transaction instruction SRAM with flush-discard of stale responses.
// Latency: data_ok to inst_valid_o 1 cycle; backpressure: no request while credits or FIFO space are exhausted.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = InstAddrWidth,
  parameter int INST_W      = InstWidth
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_bridge_if.slave bus
);

  localparam int IW  = $clog2(OUTSTANDING+1);
  localparam int OCW = $clog2(FIFO_DEPTH+1);

  logic [IW-1:0]              in_flight_q, in_flight_d, discard_q, discard_d;
  logic                       credit, sram_req, addr_hs, data_hs, drop, deliver, of_pop;
  logic [ADDR_W-1:0]          pcq_head;
  logic [IW-1:0]              pcq_count;
  logic [ADDR_W+INST_W-1:0]   of_head;
  logic [OCW-1:0]             of_count;

  // FIFO space is reserved at issue time, so buffered plus in-flight never exceeds depth.
  assign credit   = (32'(in_flight_q) < OUTSTANDING) &&
                    (32'(in_flight_q) + 32'(of_count) < FIFO_DEPTH);
  assign sram_req = rst && bus.fetch_req_i && credit && !bus.flush_i;
  assign addr_hs  = sram_req && bus.sram_addr_ok_i[0];
  assign data_hs  = bus.sram_data_ok_i[0] && (in_flight_q != '0);
  assign drop     = bus.flush_i || (discard_q != '0);
  assign deliver  = data_hs && !drop && (pcq_count != '0);
  assign of_pop   = bus.inst_valid_o && bus.inst_ready_i;

  always_comb begin
    in_flight_d = in_flight_q;
    if (addr_hs && !data_hs)      in_flight_d = in_flight_q + IW'(1);
    else if (!addr_hs && data_hs) in_flight_d = in_flight_q - IW'(1);

    discard_d = discard_q;
    // Every request still outstanding after a redirect belongs to the wrong path.
    if (bus.flush_i)                           discard_d = in_flight_d;
    else if (data_hs && (discard_q != '0))     discard_d = discard_q - IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight_q <= '0;
      discard_q   <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
    end
  end

  inst_fetch_bridge_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(OUTSTANDING)) u_pc_q (
    .clk      (clk),
    .rst      (rst),
    .push_vld (addr_hs),
    .push_dat (bus.fetch_pc_i),
    .pop_rdy  (deliver),
    .clr      (bus.flush_i),
    .head_dat (pcq_head),
    .count    (pcq_count)
  );

  inst_fetch_bridge_sync_fifo #(.WIDTH(ADDR_W+INST_W), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk      (clk),
    .rst      (rst),
    .push_vld (deliver),
    .push_dat ({pcq_head, bus.sram_rdata_i}),
    .pop_rdy  (of_pop),
    .clr      (bus.flush_i),
    .head_dat (of_head),
    .count    (of_count)
  );

  assign bus.sram_req_o             = sram_req;
  assign bus.sram_addr_o            = bus.fetch_pc_i;
  assign bus.fetch_ready_o          = addr_hs;
  assign bus.inst_valid_o           = (of_count != '0);
  assign {bus.inst_pc_o, bus.inst_o} = of_head;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed scenarios plus randomized traffic against a queue-based model of the fetch bridge.
module tb_inst_fetch_bridge;

  localparam int OUTS = 2;
  localparam int FD   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  inst_fetch_bridge_if bus ();

  inst_fetch_bridge #(.OUTSTANDING(OUTS), .FIFO_DEPTH(FD), .ADDR_W(32), .INST_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.fetch_req_i    = 1'b0;
    bus.fetch_pc_i     = '0;
    bus.flush_i        = 1'b0;
    bus.inst_ready_i   = 1'b0;
    bus.sram_addr_ok_i = 1'b0;
    bus.sram_data_ok_i = 1'b0;
    bus.sram_rdata_i   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    bus.fetch_req_i = 1'b1;
    bus.fetch_pc_i  = 32'h1C00_0000;
    bus.sram_addr_ok_i = 1'b1;
    settle();
    vectors++; if (bus.sram_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %0h want 0", bus.sram_req_o); end
    vectors++; if (bus.fetch_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0h want 0", bus.fetch_ready_o); end
    vectors++; if (bus.inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0h want 0", bus.inst_valid_o); end
    vectors++; if (bus.inst_o !== 32'h0 || bus.inst_pc_o !== 32'h0) begin miscompares++; $display("FAIL reset_head: got %0h/%0h want 0/0", bus.inst_pc_o, bus.inst_o); end
    rst = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    vectors++; if (bus.sram_req_o !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_req: got %0h want 0", bus.sram_req_o); end
    bus.flush_i = 1'b0;
    #1;
    vectors++; if (bus.sram_req_o !== 1'b1) begin miscompares++; $display("FAIL req_after_flush: got %0h want 1", bus.sram_req_o); end
    idle();
    tick();
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus.fetch_req_i = 1'b1; bus.fetch_pc_i = 32'h1C00_0000; bus.sram_addr_ok_i = 1'b1;
    settle();
    vectors++; if (bus.fetch_ready_o !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %0h want 1", bus.fetch_ready_o); end
    vectors++; if (bus.sram_addr_o !== 32'h1C00_0000) begin miscompares++; $display("FAIL single_addr: got %0h want 1c000000", bus.sram_addr_o); end
    tick();
    idle();
    tick();
    bus.sram_data_ok_i = 1'b1; bus.sram_rdata_i = 32'h0280_0C21;
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass: got %0h want 0", bus.inst_valid_o); end
    tick();
    idle();
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0h want 1", bus.inst_valid_o); end
    vectors++; if (bus.inst_pc_o !== 32'h1C00_0000) begin miscompares++; $display("FAIL single_pc: got %0h want 1c000000", bus.inst_pc_o); end
    vectors++; if (bus.inst_o !== 32'h0280_0C21) begin miscompares++; $display("FAIL single_inst: got %0h want 2800c21", bus.inst_o); end
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_popped: got %0h want 0", bus.inst_valid_o); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] issued[$];
    logic [31:0] pc;
    logic        rdy, dok;
    int          n_acc;
    do_reset();
    pc = 32'h1C00_0000; n_acc = 0;
    bus.fetch_req_i = 1'b1; bus.sram_addr_ok_i = 1'b1; bus.sram_data_ok_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.fetch_pc_i   = pc;
      bus.sram_rdata_i = (issued.size() > 0) ? ~issued[0] : 32'h0;
      settle();
      rdy = bus.fetch_ready_o;
      dok = issued.size() > 0;
      tick();
      if (dok) void'(issued.pop_front());
      if (rdy) begin issued.push_back(pc); pc = pc + 32'd4; n_acc++; end
    end
    bus.fetch_pc_i = pc;
    settle();
    vectors++; if (n_acc !== 4) begin miscompares++; $display("FAIL bp_accepted: got %0d want 4", n_acc); end
    vectors++; if (bus.sram_req_o !== 1'b0 || bus.fetch_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_stalled: got req %0h rdy %0h want 0 0", bus.sram_req_o, bus.fetch_ready_o); end
    vectors++; if (bus.inst_pc_o !== 32'h1C00_0000 || bus.inst_o !== ~32'h1C00_0000) begin miscompares++; $display("FAIL bp_head: got %0h/%0h want 1c000000/%0h", bus.inst_pc_o, bus.inst_o, ~32'h1C00_0000); end
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    settle();
    vectors++; if (bus.sram_req_o !== 1'b1 || bus.fetch_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_resume: got req %0h rdy %0h want 1 1", bus.sram_req_o, bus.fetch_ready_o); end
    vectors++; if (bus.sram_addr_o !== 32'h1C00_0010) begin miscompares++; $display("FAIL bp_resume_addr: got %0h want 1c000010", bus.sram_addr_o); end
    vectors++; if (bus.inst_pc_o !== 32'h1C00_0004) begin miscompares++; $display("FAIL bp_next_head: got %0h want 1c000004", bus.inst_pc_o); end
    tick();
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    bus.sram_addr_ok_i = 1'b1;
    bus.fetch_req_i = 1'b1; bus.fetch_pc_i = 32'h0FC;
    tick();
    bus.fetch_pc_i = 32'h100; bus.sram_data_ok_i = 1'b1; bus.sram_rdata_i = 32'hAAAA_0000;
    tick();
    bus.fetch_pc_i = 32'h104; bus.sram_data_ok_i = 1'b0;
    tick();
    bus.fetch_pc_i = 32'h200; bus.flush_i = 1'b1;
    settle();
    vectors++; if (bus.sram_req_o !== 1'b0) begin miscompares++; $display("FAIL flush_no_req: got %0h want 0", bus.sram_req_o); end
    vectors++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h0FC) begin miscompares++; $display("FAIL flush_pre_buf: got %0h/%0h want 1/fc", bus.inst_valid_o, bus.inst_pc_o); end
    tick();
    bus.flush_i = 1'b0; bus.sram_data_ok_i = 1'b1; bus.sram_rdata_i = 32'hBAD1;
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_emptied: got %0h want 0", bus.inst_valid_o); end
    tick();
    bus.sram_rdata_i = 32'hBAD2;
    settle();
    vectors++; if (bus.fetch_ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_new_req: got %0h want 1", bus.fetch_ready_o); end
    tick();
    bus.fetch_req_i = 1'b0; bus.sram_rdata_i = 32'h600D;
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_stale_dropped: got %0h want 0", bus.inst_valid_o); end
    tick();
    bus.sram_data_ok_i = 1'b0;
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h200 || bus.inst_o !== 32'h600D) begin miscompares++; $display("FAIL flush_deliver: got %0h/%0h/%0h want 1/200/600d", bus.inst_valid_o, bus.inst_pc_o, bus.inst_o); end
    idle();
  endtask

  task automatic test_flush_data_ok();
    do_reset();
    bus.sram_addr_ok_i = 1'b1;
    bus.fetch_req_i = 1'b1; bus.fetch_pc_i = 32'hA0;
    tick();
    bus.fetch_pc_i = 32'hA4;
    tick();
    bus.fetch_req_i = 1'b0; bus.flush_i = 1'b1; bus.sram_data_ok_i = 1'b1; bus.sram_rdata_i = 32'hBAD0;
    tick();
    bus.flush_i = 1'b0; bus.fetch_req_i = 1'b1; bus.fetch_pc_i = 32'hB0; bus.sram_rdata_i = 32'hBAD4;
    settle();
    vectors++; if (bus.fetch_ready_o !== 1'b1 || bus.inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL fdo_state: got rdy %0h vld %0h want 1 0", bus.fetch_ready_o, bus.inst_valid_o); end
    tick();
    bus.fetch_req_i = 1'b0; bus.sram_rdata_i = 32'hC0DE;
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b0) begin miscompares++; $display("FAIL fdo_second_drop: got %0h want 0", bus.inst_valid_o); end
    tick();
    bus.sram_data_ok_i = 1'b0;
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'hB0 || bus.inst_o !== 32'hC0DE) begin miscompares++; $display("FAIL fdo_deliver: got %0h/%0h/%0h want 1/b0/c0de", bus.inst_valid_o, bus.inst_pc_o, bus.inst_o); end
    idle();
  endtask

  task automatic test_addr_stall();
    do_reset();
    bus.fetch_req_i = 1'b1; bus.fetch_pc_i = 32'h3000;
    for (int c = 0; c < 3; c++) begin
      settle();
      vectors++; if (bus.sram_req_o !== 1'b1 || bus.sram_addr_o !== 32'h3000 || bus.fetch_ready_o !== 1'b0) begin miscompares++; $display("FAIL stall_c%0d: got req %0h addr %0h rdy %0h want 1 3000 0", c, bus.sram_req_o, bus.sram_addr_o, bus.fetch_ready_o); end
      tick();
    end
    bus.sram_addr_ok_i = 1'b1;
    settle();
    vectors++; if (bus.fetch_ready_o !== 1'b1) begin miscompares++; $display("FAIL stall_accept: got %0h want 1", bus.fetch_ready_o); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc;
    do_reset();
    pc = 32'h1C00_1000;
    bus.fetch_req_i = 1'b1; bus.sram_addr_ok_i = 1'b1; bus.sram_data_ok_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.fetch_pc_i = pc; bus.sram_rdata_i = pc ^ 32'hFFFF;
      tick();
      pc = pc + 32'd4;
    end
    bus.sram_data_ok_i = 1'b0; bus.fetch_pc_i = pc;
    vectors++; if (bus.inst_valid_o !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: got %0h want 1", bus.inst_valid_o); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (bus.inst_valid_o !== 1'b0 || bus.sram_req_o !== 1'b0 || bus.fetch_ready_o !== 1'b0) begin miscompares++; $display("FAIL rmid_async: got vld %0h req %0h rdy %0h want 0 0 0", bus.inst_valid_o, bus.sram_req_o, bus.fetch_ready_o); end
    #1 rst = 1'b1;
    bus.fetch_pc_i = 32'h1C00_4000;
    #1;
    vectors++; if (bus.fetch_ready_o !== 1'b1) begin miscompares++; $display("FAIL rmid_fresh_req: got %0h want 1", bus.fetch_ready_o); end
    tick();
    bus.fetch_req_i = 1'b0;
    tick();
    bus.sram_data_ok_i = 1'b1; bus.sram_rdata_i = 32'h1234;
    tick();
    bus.sram_data_ok_i = 1'b0;
    settle();
    vectors++; if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h1C00_4000 || bus.inst_o !== 32'h1234) begin miscompares++; $display("FAIL rmid_fresh: got %0h/%0h/%0h want 1/1c004000/1234", bus.inst_valid_o, bus.inst_pc_o, bus.inst_o); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] mq_pc[$];
    bit          mq_st[$];
    logic [31:0] bq_pc[$];
    logic [31:0] bq_in[$];
    logic [31:0] p, exp_pc, exp_inst;
    bit          s, hold, credit, exp_req, exp_rdy, exp_vld;
    do_reset();
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.flush_i = ($urandom_range(0, 19) == 0);
      if (!hold) begin
        bus.fetch_req_i = ($urandom_range(0, 3) != 0);
        bus.fetch_pc_i  = $urandom() & 32'hFFFF_FFFC;
      end
      bus.sram_addr_ok_i = ($urandom_range(0, 2) != 0);
      bus.sram_data_ok_i = (mq_pc.size() > 0) ? $urandom_range(0, 1) : ($urandom_range(0, 9) == 0);
      bus.sram_rdata_i   = $urandom();
      bus.inst_ready_i   = ($urandom_range(0, 2) != 0);
      settle();
      credit   = (mq_pc.size() < OUTS) && (mq_pc.size() + bq_pc.size() < FD);
      exp_req  = bus.fetch_req_i && credit && !bus.flush_i;
      exp_rdy  = exp_req && bus.sram_addr_ok_i[0];
      exp_vld  = bq_pc.size() > 0;
      exp_pc   = exp_vld ? bq_pc[0] : 32'h0;
      exp_inst = exp_vld ? bq_in[0] : 32'h0;
      vectors++; if (bus.sram_req_o !== exp_req) begin miscompares++; $display("FAIL rnd_req c%0d: got %0h want %0h", c, bus.sram_req_o, exp_req); end
      vectors++; if (bus.fetch_ready_o !== exp_rdy) begin miscompares++; $display("FAIL rnd_ready c%0d: got %0h want %0h", c, bus.fetch_ready_o, exp_rdy); end
      vectors++; if (bus.sram_addr_o !== bus.fetch_pc_i) begin miscompares++; $display("FAIL rnd_addr c%0d: got %0h want %0h", c, bus.sram_addr_o, bus.fetch_pc_i); end
      vectors++; if (bus.inst_valid_o !== exp_vld) begin miscompares++; $display("FAIL rnd_valid c%0d: got %0h want %0h", c, bus.inst_valid_o, exp_vld); end
      vectors++; if (bus.inst_pc_o !== exp_pc || bus.inst_o !== exp_inst) begin miscompares++; $display("FAIL rnd_head c%0d: got %0h/%0h want %0h/%0h", c, bus.inst_pc_o, bus.inst_o, exp_pc, exp_inst); end
      tick();
      if (exp_vld && bus.inst_ready_i) begin void'(bq_pc.pop_front()); void'(bq_in.pop_front()); end
      if (bus.sram_data_ok_i[0] && mq_pc.size() > 0) begin
        p = mq_pc.pop_front();
        s = mq_st.pop_front();
        if (!s && !bus.flush_i) begin bq_pc.push_back(p); bq_in.push_back(bus.sram_rdata_i); end
      end
      if (bus.flush_i) begin
        bq_pc.delete(); bq_in.delete();
        foreach (mq_st[i]) mq_st[i] = 1'b1;
      end
      if (exp_rdy) begin mq_pc.push_back(bus.fetch_pc_i); mq_st.push_back(1'b0); end
      hold = bus.fetch_req_i && !exp_rdy && !bus.flush_i;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_fetch();
    test_back_pressure();
    test_flush();
    test_flush_data_ok();
    test_addr_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
    $fatal(1, "time limit");
  end

endmodule
